// File: rtl/b06_mc_pkg.sv
// rtl/b06_mc_pkg.sv - state encoding and cc_mux/uscite code constants for b06_mc_ctrl
package b06_mc_pkg;

  // INIT..INTR_W keep the legacy b06 encodings; TMO takes the spare code
  typedef enum logic [2:0] {
    ST_INIT   = 3'b000,
    ST_WAIT   = 3'b001,
    ST_ENIN   = 3'b010,
    ST_ENIN_W = 3'b011,
    ST_INTR   = 3'b100,
    ST_INTR_1 = 3'b101,
    ST_INTR_W = 3'b110,
    ST_TMO    = 3'b111
  } state_t;

  localparam logic [1:0] CC_NONE  = 2'b00;
  localparam logic [1:0] CC_ENIN  = 2'b01;
  localparam logic [1:0] CC_INTR  = 2'b10;
  localparam logic [1:0] CC_ACKIN = 2'b11;

  localparam logic [1:0] OUT_NONE = 2'b00;
  localparam logic [1:0] OUT_NORM = 2'b01;
  localparam logic [1:0] OUT_TMO  = 2'b10;
  localparam logic [1:0] OUT_INTR = 2'b11;

  function automatic logic is_idle(state_t s);
    return (s == ST_INIT) || (s == ST_WAIT) || (s == ST_INTR_1);
  endfunction

endpackage

// File: rtl/b06_mc_rr_arb.sv
// rtl/b06_mc_rr_arb.sv - combinational round-robin pick starting at rr_ptr
module b06_mc_rr_arb #(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] eql,
  input  logic [CW-1:0]  rr_ptr,
  output logic           valid,
  output logic [CW-1:0]  winner
);

  logic [CW-1:0] idx;

  // Scan from the farthest offset back to rr_ptr so the closest hit wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = CW'((int'(rr_ptr) + i) % NCH);
      if (eql[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/b06_mc_ctrl.sv
// rtl/b06_mc_ctrl.sv - multi-channel b06 handshake controller; stuck-request timeout under B06_MC_TIMEOUT_EN
module b06_mc_ctrl
  import b06_mc_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CW      = $clog2(NCH),
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 200
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [NCH-1:0] eql,
  input  logic           cont_eql,
  output logic [1:0]     cc_mux,
  output logic [1:0]     uscite,
  output logic           enable_count,
  output logic [NCH-1:0] ackout,
  output logic [CW-1:0]  chan,
  output logic           busy,
  output logic           tmo_err
);

  state_t         state, state_nx;
  logic [CW-1:0]  rr_ptr, rr_ptr_nx, chan_nx, ptr_after;
  logic [1:0]     cc_nx, us_nx;
  logic           en_nx, tmo_nx, req, in_hs, tmo_hit;
  logic [NCH-1:0] ack_nx, chan_onehot;
  logic           arb_valid;
  logic [CW-1:0]  arb_winner;

  b06_mc_rr_arb #(.NCH(NCH), .CW(CW)) u_arb (
    .eql    (eql),
    .rr_ptr (rr_ptr),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  assign req         = eql[chan];
  assign chan_onehot = {{(NCH-1){1'b0}}, 1'b1} << chan;
  assign ptr_after   = (arb_winner == CW'(NCH - 1)) ? '0 : arb_winner + CW'(1);
  assign in_hs       = (state == ST_ENIN) || (state == ST_ENIN_W) ||
                       (state == ST_INTR) || (state == ST_INTR_W);

`ifdef B06_MC_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = in_hs && req && (tmo_cnt == TMO_W'(TMO_MAX - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state_nx != state) begin
      tmo_cnt <= '0;
    end else if (in_hs && req) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  logic unused_tmo_cfg;

  assign tmo_hit        = 1'b0;
  assign unused_tmo_cfg = (TMO_W > 0) ^ (TMO_MAX > 0) ^ in_hs;
`endif

  always_comb begin
    state_nx  = state;
    chan_nx   = chan;
    rr_ptr_nx = rr_ptr;
    cc_nx     = cc_mux;
    us_nx     = uscite;
    en_nx     = ~cont_eql;
    ack_nx    = cont_eql ? '0 : chan_onehot;
    case (state)
      ST_INIT: begin
        cc_nx    = CC_ENIN;
        us_nx    = OUT_NORM;
        state_nx = ST_WAIT;
      end
      ST_WAIT, ST_INTR_1: begin
        if (arb_valid) begin
          chan_nx   = arb_winner;
          rr_ptr_nx = ptr_after;
          us_nx     = OUT_NONE;
          cc_nx     = CC_ACKIN;
          state_nx  = (state == ST_WAIT) ? ST_ENIN : ST_INTR;
        end else begin
          us_nx    = OUT_NORM;
          cc_nx    = (state == ST_WAIT) ? CC_INTR : CC_ENIN;
          state_nx = (state == ST_WAIT) ? ST_INTR_1 : ST_WAIT;
        end
      end
      ST_ENIN: begin
        if (req) begin
          us_nx = OUT_NONE;
          cc_nx = CC_ACKIN;
        end else begin
          // Exit cycle acknowledges regardless of cont_eql.
          us_nx    = OUT_NORM;
          cc_nx    = CC_ENIN;
          en_nx    = 1'b1;
          ack_nx   = chan_onehot;
          state_nx = ST_ENIN_W;
        end
      end
      ST_ENIN_W: begin
        us_nx = OUT_NORM;
        cc_nx = CC_ENIN;
        if (!req) state_nx = ST_WAIT;
      end
      ST_INTR: begin
        if (req) begin
          us_nx = OUT_NONE;
          cc_nx = CC_ACKIN;
        end else begin
          us_nx    = OUT_INTR;
          cc_nx    = CC_INTR;
          state_nx = ST_INTR_W;
        end
      end
      ST_INTR_W: begin
        if (req) begin
          us_nx = OUT_INTR;
          cc_nx = CC_INTR;
        end else begin
          us_nx    = OUT_NORM;
          cc_nx    = CC_ENIN;
          state_nx = ST_WAIT;
        end
      end
      ST_TMO: begin
        if (req) begin
          us_nx = OUT_TMO;
          cc_nx = CC_NONE;
        end else begin
          us_nx    = OUT_NORM;
          cc_nx    = CC_ENIN;
          state_nx = ST_WAIT;
        end
      end
      default: state_nx = ST_INIT;
    endcase
    if (tmo_hit) begin
      state_nx = ST_TMO;
      us_nx    = OUT_TMO;
      cc_nx    = CC_NONE;
    end
    tmo_nx = (state_nx == ST_TMO) && (state != ST_TMO);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= ST_INIT;
      rr_ptr       <= '0;
      chan         <= '0;
      cc_mux       <= '0;
      uscite       <= '0;
      enable_count <= 1'b0;
      ackout       <= '0;
      busy         <= 1'b0;
      tmo_err      <= 1'b0;
    end else begin
      state        <= state_nx;
      rr_ptr       <= rr_ptr_nx;
      chan         <= chan_nx;
      cc_mux       <= cc_nx;
      uscite       <= us_nx;
      enable_count <= en_nx;
      ackout       <= ack_nx;
      busy         <= !is_idle(state_nx);
      tmo_err      <= tmo_nx;
    end
  end

endmodule

// File: tb/tb_b06_mc_ctrl.sv
// tb/tb_b06_mc_ctrl.sv - self-checking bench for b06_mc_ctrl; timeout scenario under B06_MC_TIMEOUT_EN
module tb_b06_mc_ctrl;

  localparam int NCH    = 4;
  localparam int CW     = 2;
  localparam int TMO_TB = 5;

  localparam int PH_INIT = 0, PH_WAIT = 1, PH_POLL = 2, PH_EACK = 3;
  localparam int PH_EDONE = 4, PH_IACK = 5, PH_IDONE = 6, PH_TMO = 7;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [NCH-1:0] eql = '0;
  logic           cont_eql = 1'b1;
  logic [1:0]     cc_mux, uscite;
  logic           enable_count, busy, tmo_err;
  logic [NCH-1:0] ackout;
  logic [CW-1:0]  chan;

  int n_cmp = 0;
  int n_err = 0;

  int             m_ph = PH_INIT, m_ptr = 0, m_chan = 0, m_cnt = 0;
  logic [1:0]     m_cc = '0, m_us = '0;
  logic           m_en = 1'b0, m_busy = 1'b0, m_tmo = 1'b0;
  logic [NCH-1:0] m_ack = '0;

  always #5 clock = ~clock;

  b06_mc_ctrl #(.NCH(NCH), .CW(CW), .TMO_W(8), .TMO_MAX(TMO_TB)) dut (
    .clock        (clock),
    .reset        (reset),
    .eql          (eql),
    .cont_eql     (cont_eql),
    .cc_mux       (cc_mux),
    .uscite       (uscite),
    .enable_count (enable_count),
    .ackout       (ackout),
    .chan         (chan),
    .busy         (busy),
    .tmo_err      (tmo_err)
  );

  function automatic logic [NCH-1:0] onehot(int c);
    logic [NCH-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  function automatic int rr_pick(logic [NCH-1:0] r, int p);
    for (int k = 0; k < NCH; k++) if (r[(p + k) % NCH]) return (p + k) % NCH;
    return -1;
  endfunction

  function automatic logic [12:0] dut_vec();
    return {cc_mux, uscite, enable_count, ackout, chan, busy, tmo_err};
  endfunction

  function automatic logic [12:0] mdl_vec();
    logic [CW-1:0] c;
    c = m_chan[CW-1:0];
    return {m_cc, m_us, m_en, m_ack, c, m_busy, m_tmo};
  endfunction

  // Reference behaviour: one call per rising edge, reading the inputs seen at that edge.
  task automatic model_step();
    int nph, w;
    bit req, hs;
    if (!reset) begin
      m_ph = PH_INIT; m_ptr = 0; m_chan = 0; m_cnt = 0;
      m_cc = 2'd0; m_us = 2'd0; m_en = 1'b0; m_ack = '0; m_busy = 1'b0; m_tmo = 1'b0;
      return;
    end
    req   = eql[m_chan];
    hs    = (m_ph == PH_EACK) || (m_ph == PH_EDONE) || (m_ph == PH_IACK) || (m_ph == PH_IDONE);
    nph   = m_ph;
    m_en  = !cont_eql;
    m_ack = cont_eql ? '0 : onehot(m_chan);
    case (m_ph)
      PH_INIT: begin m_cc = 2'd1; m_us = 2'd1; nph = PH_WAIT; end
      PH_WAIT, PH_POLL: begin
        w = rr_pick(eql, m_ptr);
        if (w >= 0) begin
          m_chan = w; m_ptr = (w + 1) % NCH; m_us = 2'd0; m_cc = 2'd3;
          nph = (m_ph == PH_WAIT) ? PH_EACK : PH_IACK;
        end else if (m_ph == PH_WAIT) begin
          m_us = 2'd1; m_cc = 2'd2; nph = PH_POLL;
        end else begin
          m_us = 2'd1; m_cc = 2'd1; nph = PH_WAIT;
        end
      end
      PH_EACK: if (req) begin m_us = 2'd0; m_cc = 2'd3; end
               else begin m_us = 2'd1; m_cc = 2'd1; m_en = 1'b1; m_ack = onehot(m_chan); nph = PH_EDONE; end
      PH_EDONE: begin m_us = 2'd1; m_cc = 2'd1; if (!req) nph = PH_WAIT; end
      PH_IACK: if (req) begin m_us = 2'd0; m_cc = 2'd3; end
               else begin m_us = 2'd3; m_cc = 2'd2; nph = PH_IDONE; end
      PH_IDONE: if (req) begin m_us = 2'd3; m_cc = 2'd2; end
                else begin m_us = 2'd1; m_cc = 2'd1; nph = PH_WAIT; end
      PH_TMO: if (req) begin m_us = 2'd2; m_cc = 2'd0; end
              else begin m_us = 2'd1; m_cc = 2'd1; nph = PH_WAIT; end
      default: nph = PH_INIT;
    endcase
`ifdef B06_MC_TIMEOUT_EN
    if (hs && req && m_cnt == TMO_TB - 1) begin nph = PH_TMO; m_us = 2'd2; m_cc = 2'd0; end
    if (nph != m_ph) m_cnt = 0;
    else if (hs && req) m_cnt++;
`else
    hs = 1'b0;
`endif
    m_tmo  = (nph == PH_TMO) && (m_ph != PH_TMO);
    m_busy = !(nph == PH_INIT || nph == PH_WAIT || nph == PH_POLL);
    m_ph   = nph;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; eql = '0; cont_eql = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; eql = 4'b1111; cont_eql = 1'b0;
    tick(); tick();
    n_cmp++;
    if (dut_vec() !== 13'd0) begin
      n_err++; $display("FAIL reset_outputs: got %b want 0", dut_vec());
    end
    reset = 1'b1; eql = '0; cont_eql = 1'b1;
    tick();
    n_cmp++;
    if ({cc_mux, uscite, busy} !== 5'b01010) begin
      n_err++; $display("FAIL reset_release: cc/us/busy got %b want 01010", {cc_mux, uscite, busy});
    end
    tick();
    n_cmp++;
    if (dut_vec() !== mdl_vec()) begin
      n_err++; $display("FAIL reset_to_poll: got %b want %b", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_enable_path();
    logic [1:0] us_seq [3];
    do_reset();
    eql = 4'b0100; cont_eql = 1'b1;
    tick(); us_seq[0] = uscite;
    n_cmp++;
    if (chan !== 2'd2) begin n_err++; $display("FAIL enable_chan: got %0d want 2", chan); end
    eql = '0;
    tick(); us_seq[1] = uscite;
    n_cmp++;
    if ({ackout, enable_count} !== 5'b01001) begin
      n_err++; $display("FAIL enable_ack: got %b want 01001", {ackout, enable_count});
    end
    tick(); us_seq[2] = uscite;
    n_cmp++;
    if ({us_seq[0], us_seq[1], us_seq[2]} !== 6'b000101) begin
      n_err++; $display("FAIL enable_uscite: got %b want 000101", {us_seq[0], us_seq[1], us_seq[2]});
    end
  endtask

  task automatic test_round_robin();
    int exp_g [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int p = 0; p < 5; p++) begin
      eql = 4'b1111;
      tick();
      n_cmp++;
      if (int'(chan) !== exp_g[p]) begin
        n_err++; $display("FAIL rr_grant%0d: got %0d want %0d", p, chan, exp_g[p]);
      end
      eql = '0;
      tick(); tick();
    end
  endtask

  task automatic test_interrupt_path();
    logic [1:0] cc_seq [5];
    do_reset();
    eql = '0;
    tick(); cc_seq[0] = cc_mux;
    eql = 4'b0001;
    for (int i = 1; i <= 3; i++) begin tick(); cc_seq[i] = cc_mux; end
    eql = '0;
    tick(); cc_seq[4] = cc_mux;
    n_cmp++;
    if ({cc_seq[0], cc_seq[1], cc_seq[2], cc_seq[3], cc_seq[4]} !== 10'b1011111110) begin
      n_err++; $display("FAIL intr_cc_seq: got %b want 1011111110",
                        {cc_seq[0], cc_seq[1], cc_seq[2], cc_seq[3], cc_seq[4]});
    end
    n_cmp++;
    if ({uscite, busy} !== 3'b111) begin
      n_err++; $display("FAIL intr_w_uscite: got %b want 111", {uscite, busy});
    end
    tick();
    n_cmp++;
    if ({cc_mux, uscite, busy} !== 5'b01010) begin
      n_err++; $display("FAIL intr_return: got %b want 01010", {cc_mux, uscite, busy});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    eql = '0;      tick();
    eql = 4'b0010; tick();
    eql = '0;      tick();
    n_cmp++;
    if ({uscite, chan} !== 4'b1101) begin
      n_err++; $display("FAIL mid_setup: got %b want 1101", {uscite, chan});
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (dut_vec() !== 13'd0) begin
      n_err++; $display("FAIL mid_reset: got %b want 0", dut_vec());
    end
    reset = 1'b1;
  endtask

`ifdef B06_MC_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    do_reset();
    eql = 4'b0010;
    tick();
    n = 0;
    while (n < 20) begin
      tick(); n++;
      if (tmo_err === 1'b1) break;
    end
    n_cmp++;
    if (n !== TMO_TB) begin n_err++; $display("FAIL tmo_latency: got %0d want %0d", n, TMO_TB); end
    n_cmp++;
    if ({uscite, cc_mux, busy} !== 5'b10001) begin
      n_err++; $display("FAIL tmo_codes: got %b want 10001", {uscite, cc_mux, busy});
    end
    tick();
    n_cmp++;
    if (tmo_err !== 1'b0) begin n_err++; $display("FAIL tmo_pulse: got %b want 0", tmo_err); end
    eql = '0;
    tick();
    n_cmp++;
    if ({uscite, cc_mux, busy} !== 5'b01010) begin
      n_err++; $display("FAIL tmo_exit: got %b want 01010", {uscite, cc_mux, busy});
    end
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    eql = 4'b0010;
    tick();
    for (int i = 0; i < 20; i++) tick();
    n_cmp++;
    if ({tmo_err, uscite, cc_mux, busy} !== 6'b000111) begin
      n_err++; $display("FAIL no_tmo_hold: got %b want 000111", {tmo_err, uscite, cc_mux, busy});
    end
    eql = '0;
    tick(); tick();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 3) == 0)
        eql = ($urandom_range(0, 1) == 0) ? '0 : NCH'($urandom_range(0, 15));
      cont_eql = $urandom_range(0, 1) == 1;
      tick();
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++; $display("FAIL random_cyc%0d: got %b want %b", i, dut_vec(), mdl_vec());
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_enable_path();
    test_round_robin();
    test_interrupt_path();
    test_reset_mid();
`ifdef B06_MC_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/b06_mc_ctrl.md
# b06_mc_ctrl

Multi-channel interrupt/enable handshake controller: the parametrised successor of the single-channel b06 FSM. It serves `NCH` request lines (`eql`) through one shared handshake sequencer, choosing among requesters with a round-robin arbiter. It drives the same `cc_mux`/`uscite` code space plus a one-hot per-channel acknowledge, and adds a compile-time optional stuck-request timeout. It sits between the request sources and the shared counter/mux datapath.

## Interface
- `NCH`, 4: number of request channels (2..16)
- `CW`, `$clog2(NCH)`: channel index width
- `TMO_W`, 8: timeout counter width
- `TMO_MAX`, 200: cycles a granted request may stay high before timeout (1..2^TMO_W-1)

- `clock`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-low reset
- `eql`  in  NCH  per-channel request/equal flags
- `cont_eql`  in  1  counter-equal flag; gates `ackout`/`enable_count`
- `cc_mux`  out  2  mux control code
- `uscite`  out  2  status output code
- `enable_count`  out  1  counter enable
- `ackout`  out  NCH  one-hot acknowledge to the granted channel
- `chan`  out  CW  index of the currently granted channel
- `busy`  out  1  high in any state except INIT/WAIT/INTR_1
- `tmo_err`  out  1  one-cycle pulse on timeout (0 when the macro is off)

## Operation
- All outputs are registered. Reset (`reset`=0 at an edge) sets state INIT, `rr_ptr`=0, and every output, including `chan`, to 0. Reset overrides everything, mid-handshake included.
- Codes: `cc_enin`=01, `cc_intr`=10, `cc_ackin`=11, `out_norm`=01, `out_intr`=11, `out_tmo`=10.
- Every non-reset cycle, before any state-specific override:
  - `enable_count` = ~`cont_eql`.
  - `ackout` = ~`cont_eql` ? onehot(`chan`) : 0.
- Arbiter, used only in WAIT and INTR_1:
  - The grant is the first set `eql` bit searching `rr_ptr`, `rr_ptr`+1, … with wrap at NCH-1→0.
  - On a grant, `chan` ← winner and `rr_ptr` ← winner+1 (mod NCH).
- States and transitions ("req" = `eql[chan]`):
  - INIT: cc=enin, uscite=norm → WAIT.
  - WAIT:
    - Any `eql` → grant; uscite=00, cc=ackin → ENIN.
    - Else uscite=norm, cc=intr → INTR_1.
  - INTR_1:
    - Any `eql` → grant; uscite=00, cc=ackin → INTR.
    - Else uscite=norm, cc=enin → WAIT.
  - ENIN:
    - req → hold outputs (00, ackin), stay.
    - Else uscite=01, cc=enin, force `enable_count`=1 and `ackout`=onehot(`chan`) → ENIN_W.
  - ENIN_W:
    - req → uscite=01, cc=enin, stay.
    - Else uscite=norm, cc=enin → WAIT.
  - INTR:
    - req → uscite=00, cc=ackin, stay.
    - Else uscite=intr, cc=intr → INTR_W.
  - INTR_W:
    - req → uscite=intr, cc=intr, stay.
    - Else uscite=norm, cc=enin → WAIT.
  - TMO (macro only):
    - req → uscite=tmo, cc=00, stay.
    - Else uscite=norm, cc=enin → WAIT.
- Requests from other channels are ignored until the FSM returns to WAIT or INTR_1. The grant never changes mid-handshake.

## Timing
- Input to output latency is one clock: `eql` sampled at edge k is reflected in `cc_mux`/`uscite` after edge k.
- Fastest full handshake: WAIT→ENIN→ENIN_W→WAIT in 3 cycles with req pulsed for 1 cycle.
- Simultaneous requests in WAIT: exactly one grant per pass; the others are granted in rotation on later passes.
- A request dropping in the same cycle it is granted: the FSM still enters ENIN/INTR, then exits on the next cycle.
- A single active channel is regranted every pass; there is no starvation for any channel.

## Configuration
- `B06_MC_TIMEOUT_EN` defined:
  - A `TMO_W`-bit counter clears on every state change and increments each cycle the FSM stays in ENIN/ENIN_W/INTR/INTR_W with req high.
  - When the counter = `TMO_MAX`-1 and req is still high, the next state is TMO. `tmo_err` pulses for 1 cycle on entry.
- Not defined: no counter and no TMO state; `tmo_err` is tied to 0; the FSM may wait indefinitely.

## Structure
- Package `b06_mc_pkg` holds:
  - the state enum (INIT, WAIT, ENIN, ENIN_W, INTR, INTR_1, INTR_W, TMO), 3-bit, with the INIT..INTR_W encodings 000..110 kept from b06;
  - the cc/uscite code constants.
- One sub-module, `b06_mc_rr_arb`: combinational round-robin pick of (`eql`, `rr_ptr`) giving `valid` and `winner`.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `eql`=1111 → all outputs 0 and `chan`=0; then release → INIT then WAIT, with `cc_mux`=01 and `uscite`=01.
- Enable path: NCH=4, `eql`=0100 for 1 cycle in WAIT, `cont_eql`=1 → `chan`=2, `uscite` sequence 00,01,01, `ackout`=0100 on the ENIN exit cycle.
- Round-robin: `eql`=1111 held and released each pass → grants in order 0,1,2,3,0.
- Interrupt path: no `eql` in WAIT, then `eql`=0001 in INTR_1 held 3 cycles → `cc_mux` 10,11,11,11,10 and `uscite`=11 in INTR_W.
- Timeout: with the macro on, TMO_MAX=5, `eql[1]` held → TMO after 5 cycles in ENIN, `tmo_err` high 1 cycle, `uscite`=10; drop `eql` → WAIT.
- Reset mid-handshake: `reset`=0 while in INTR_W → INIT next cycle, all outputs 0.
